// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the button input path and the game-control FSM.
//   CODE_W              : width of a key code
//   key_code_t          : key code type
//   KEY_LEFT..KEY_DROP  : key index of each game button
//   lowest_set_index()  : index of the lowest set bit of a vector (0 if none)
// ---------------------------------------------------------------------------
package key_pkg;

    localparam int NUM_GAME_KEYS = 4;
    localparam int CODE_W        = 2;

    typedef logic [CODE_W-1:0] key_code_t;

    localparam key_code_t KEY_LEFT   = 2'd0;
    localparam key_code_t KEY_RIGHT  = 2'd1;
    localparam key_code_t KEY_ROTATE = 2'd2;
    localparam key_code_t KEY_DROP   = 2'd3;

    // Scans from the top down so the last hit is the lowest index.
    // Supports request vectors of up to 32 bits.
    function automatic int lowest_set_index(input logic [31:0] vec);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage : key_pkg

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Generic first-word-fall-through FIFO with synchronous clear.
//   clk        : clock, all state on posedge
//   clr        : synchronous active-high clear; overrides push and pop
//   push       : write push_data at the tail (ignored when full without pop)
//   push_data  : data to write
//   pop        : discard the head entry (ignored when empty)
//   pop_data   : current head entry, valid whenever empty=0
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle; the freed slot is exactly the one the tail now points at.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared too so the head output reads zero after a clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : sync_fifo

// File: rtl/key_event_queue.sv
// ---------------------------------------------------------------------------
// key_event_queue
// Turns one-cycle press pulses from the per-button debouncers into an
// ordered stream of key codes for the game-control FSM.
//   clk        : clock, all state on posedge
//   clr        : synchronous active-high reset
//   key_pulse  : press pulses, bit i = key i
//   ev_valid   : head event available
//   ev_code    : key index of the head event (valid when ev_valid=1)
//   ev_ready   : consumer takes the head event when ev_valid & ev_ready
//   count      : queued events, 0..DEPTH
//   overflow   : sticky, a press was merged into an unserved one
// Presses wait in a per-key pending register until the FIFO has room, so
// a busy consumer never loses presses as long as each key has at most one
// outstanding request beyond the queue. Key codes match key_pkg.
// NUM_KEYS is limited to 32 by the lowest-index helper.
// ---------------------------------------------------------------------------
module key_event_queue #(
    parameter int NUM_KEYS = 4,
    parameter int DEPTH    = 4,
    parameter int CODE_W   = $clog2(NUM_KEYS)
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [NUM_KEYS-1:0]      key_pulse,
    output logic                     ev_valid,
    output logic [CODE_W-1:0]        ev_code,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    import key_pkg::lowest_set_index;

    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic [NUM_KEYS-1:0] grant;
    logic                overflow_q, overflow_d;
    logic                fifo_full, fifo_empty;
    logic                pop_en, push_en, push_allowed;
    logic [CODE_W-1:0]   push_code;

    // Arbiter: the lowest-index pending key wins whenever the FIFO can take
    // a word this cycle, including the full-with-pop case.
    always_comb begin
        grant        = '0;
        push_code    = '0;
        pop_en       = ~fifo_empty & ev_ready;
        push_allowed = ~fifo_full | pop_en;
        push_en      = push_allowed & (|pending_q);
        if (push_en) begin
            push_code = CODE_W'(lowest_set_index(32'(pending_q)));
            grant     = NUM_KEYS'(1) << push_code;
        end
    end

    // A pulse on a key that is granted this cycle starts a fresh request;
    // a pulse on a key still waiting merges into it and counts as a drop.
    always_comb begin
        pending_d  = (pending_q & ~grant) | key_pulse;
        overflow_d = overflow_q | (|(key_pulse & pending_q & ~grant));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (push_en),
        .push_data (push_code),
        .pop       (pop_en),
        .pop_data  (ev_code),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign ev_valid = ~fifo_empty;
    assign overflow = overflow_q;

endmodule : key_event_queue

// File: tb/tb_key_event_queue.sv
// ---------------------------------------------------------------------------
// tb_key_event_queue
// Directed bench for key_event_queue with a queue-based reference model that
// is compared against the DUT on every cycle, plus literal expectations for
// the accepted event sequence of each scenario.
// ---------------------------------------------------------------------------
module tb_key_event_queue;
    import key_pkg::*;

    localparam int NUM_KEYS = 4;
    localparam int DEPTH    = 4;

    logic                   clk;
    logic                   clr;
    logic [NUM_KEYS-1:0]    key_pulse;
    logic                   ev_valid;
    logic [CODE_W-1:0]      ev_code;
    logic                   ev_ready;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    int n_checks;
    int n_fails;

    // Reference model state: queued codes, outstanding request per key,
    // sticky drop flag.
    int              m_q[$];
    bit [NUM_KEYS-1:0] m_held;
    bit              m_ovf;
    bit              m_pop;
    int              m_win;
    bit              started;

    // Codes actually handed over by the DUT.
    int seen[$];

    key_event_queue #(
        .NUM_KEYS (NUM_KEYS),
        .DEPTH    (DEPTH),
        .CODE_W   (CODE_W)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .key_pulse (key_pulse),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_ready  (ev_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and return just after the sampling edge.
    task automatic applyStimulus(input logic [NUM_KEYS-1:0] pulse,
                                 input logic ready, input logic rst);
        key_pulse = pulse;
        ev_ready  = ready;
        clr       = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ready, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus('0, ready, 1'b0);
        end
    endtask

    task automatic checkSeen(input string name, input int n, input int exp_codes[5]);
        checkOutput({name, "_len"}, seen.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < seen.size()) begin
                checkOutput({name, "_code"}, seen[i], exp_codes[i]);
            end else begin
                checkOutput({name, "_missing"}, 32'hFFFF_FFFF, exp_codes[i]);
            end
        end
    endtask

    // Reference model: at each edge the head leaves if requested, the
    // lowest outstanding key joins the tail if there is room, then new
    // presses register; a press on a key still outstanding is a drop.
    always @(posedge clk) begin
        if (clr) begin
            m_q.delete();
            m_held = '0;
            m_ovf  = 1'b0;
        end else begin
            m_pop = (m_q.size() > 0) && ev_ready;
            m_win = -1;
            if ((m_q.size() < DEPTH) || m_pop) begin
                for (int k = NUM_KEYS - 1; k >= 0; k--) begin
                    if (m_held[k]) m_win = k;
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_win >= 0) begin
                m_q.push_back(m_win);
                m_held[m_win] = 1'b0;
            end
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (key_pulse[k]) begin
                    if (m_held[k]) m_ovf = 1'b1;
                    m_held[k] = 1'b1;
                end
            end
        end
        started = 1'b1;
    end

    // Per-cycle comparison against the model, plus capture of handovers
    // that will complete at the next edge.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("ev_valid", ev_valid, (m_q.size() > 0) ? 1 : 0);
            checkOutput("count", count, m_q.size());
            checkOutput("overflow", overflow, m_ovf);
            if (m_q.size() > 0) begin
                checkOutput("ev_code", ev_code, m_q[0]);
            end
            if (ev_valid === 1'b1 && ev_ready && !clr) begin
                seen.push_back(int'(ev_code));
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        started   = 1'b0;
        m_held    = '0;
        m_ovf     = 1'b0;
        key_pulse = '0;
        ev_ready  = 1'b1;
        clr       = 1'b1;

        // Reset with presses present: they must be ignored.
        applyStimulus(4'b1111, 1'b1, 1'b1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        idle(1'b1, 2);
        checkOutput("rst_valid", ev_valid, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_code", ev_code, 0);

        // Single press on ROTATE: event appears exactly two cycles later.
        seen.delete();
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("lat_c1_valid", ev_valid, 0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("lat_c2_valid", ev_valid, 1);
        checkOutput("lat_c2_code", ev_code, KEY_ROTATE);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("lat_c3_valid", ev_valid, 0);
        checkOutput("lat_c3_count", count, 0);
        checkSeen("lat_seen", 1, '{2, 0, 0, 0, 0});

        // Simultaneous presses on keys 0,1,3 while the consumer stalls.
        seen.delete();
        applyStimulus(4'b1011, 1'b0, 1'b0);
        checkOutput("multi_count0", count, 0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("multi_count1", count, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("multi_count2", count, 2);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("multi_count3", count, 3);
        checkOutput("multi_head", ev_code, KEY_LEFT);
        idle(1'b1, 4);
        checkOutput("multi_drained", ev_valid, 0);
        checkSeen("multi_seen", 3, '{0, 1, 3, 0, 0});

        // Six presses of RIGHT while stalled: four queued, one held,
        // the sixth merges and raises overflow.
        seen.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0);
            idle(1'b0, 2);
        end
        checkOutput("ovf_count", count, DEPTH);
        checkOutput("ovf_flag", overflow, 1);
        idle(1'b1, 8);
        checkSeen("ovf_seen", 5, '{1, 1, 1, 1, 1});
        checkOutput("ovf_sticky", overflow, 1);

        // Clear, then fill the FIFO and hold DROP pending; release the
        // consumer so pop and push share one edge.
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("clr_overflow", overflow, 0);
        seen.delete();
        applyStimulus(4'b0111, 1'b0, 1'b0);
        idle(1'b0, 3);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("full_count", count, DEPTH);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        idle(1'b0, 2);
        checkOutput("full_hold_count", count, DEPTH);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("full_swap_count", count, DEPTH);
        idle(1'b1, 6);
        checkSeen("full_seen", 5, '{0, 1, 2, 0, 3});
        checkOutput("full_overflow", overflow, 0);

        // Clear mid-operation with a coincident press: everything discarded.
        applyStimulus(4'b1111, 1'b0, 1'b0);
        idle(1'b0, 3);
        checkOutput("midclr_pre_count", count, 3);
        applyStimulus(4'b0100, 1'b1, 1'b1);
        seen.delete();
        checkOutput("midclr_valid", ev_valid, 0);
        checkOutput("midclr_count", count, 0);
        idle(1'b1, 6);
        checkOutput("midclr_seen", seen.size(), 0);
        checkOutput("midclr_overflow", overflow, 0);

        // Re-press LEFT on the cycle its request is granted: two events.
        seen.delete();
        applyStimulus(4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        idle(1'b1, 5);
        checkSeen("rearm_seen", 2, '{0, 0, 0, 0, 0});
        checkOutput("rearm_overflow", overflow, 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule : tb_key_event_queue
